// File: rtl/cordic_mul_pipe.sv
// Pipelined signed multiplier for the CORDIC datapath with fractional shift,
// optional round-half-up, and wrap/saturate narrowing with overflow flag.
module cordic_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 30,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND_MODE = 0,
  parameter int SAT        = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int L   = NUM_STAGE - 1;
  localparam int PW  = din0_WIDTH + din1_WIDTH;
  localparam int RW  = PW + 1;
  localparam int XW  = ((RW > dout_WIDTH) ? RW : dout_WIDTH) + 1;
  localparam int RSH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

  localparam logic [RW-1:0] RND_ONE = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RND =
    (ROUND_MODE == 1 && FRAC_SHIFT > 0) ? (RND_ONE << RSH) : '0;

  localparam logic signed [XW-1:0] MAXV =
    {{(XW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  localparam logic [dout_WIDTH-1:0] DMAX =
    {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DMIN = ~DMAX;

  logic signed [PW-1:0]         prod_c;
  logic signed [PW-1:0]         pp;
  logic signed [RW-1:0]         r_c;
  logic signed [RW-1:0]         s_c;
  logic signed [XW-1:0]         x_c;
  logic                         ovf_d;
  logic signed [dout_WIDTH-1:0] dout_d;
  logic                         unused_ok;

  assign unused_ok = ^{clk, reset, ce, 1'(ID)};

  assign prod_c = PW'(din0) * PW'(din1);

  // Post-processing sits just before the output register, after the product chain.
  always_comb begin
    r_c    = {pp[PW-1], pp} + RND;
    s_c    = r_c >>> FRAC_SHIFT;
    x_c    = {{(XW-RW){s_c[RW-1]}}, s_c};
    ovf_d  = (x_c > MAXV) || (x_c < MINV);
    dout_d = x_c[dout_WIDTH-1:0];
    if (SAT != 0 && ovf_d) begin
      dout_d = x_c[XW-1] ? DMIN : DMAX;
    end
  end

  if (L == 0) begin : g_comb
    assign pp        = prod_c;
    assign out_valid = in_valid;
    assign dout      = dout_d;
    assign ovf       = ovf_d;
  end else begin : g_pipe
    logic [L-1:0]                 vld_q;
    logic signed [dout_WIDTH-1:0] dout_q;
    logic                         ovf_q;

    if (L == 1) begin : g_p0
      assign pp = prod_c;
    end else begin : g_pn
      logic signed [PW-1:0] prod_q [L-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < L-1; i++) prod_q[i] <= '0;
        end else if (ce) begin
          prod_q[0] <= prod_c;
          for (int i = 1; i < L-1; i++) prod_q[i] <= prod_q[i-1];
        end
      end

      assign pp = prod_q[L-2];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= '0;
        dout_q <= '0;
        ovf_q  <= 1'b0;
      end else if (ce) begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < L; i++) vld_q[i] <= vld_q[i-1];
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
      end
    end

    assign out_valid = vld_q[L-1];
    assign dout      = dout_q;
    assign ovf       = ovf_q;
  end

endmodule

// File: tb/tb_cordic_mul_pipe.sv
// Randomised and directed bench for cordic_mul_pipe across several
// parameter sets, checked against an integer reference model.
module tb_cordic_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               ce;
  logic               in_valid;
  logic signed [16:0] din0;
  logic signed [15:0] din1;

  logic               v_def, v_sat, v_rnd, v_trn, v_ns1, v_ns5;
  logic signed [29:0] d_def, d_sat, d_rnd, d_trn, d_ns1, d_ns5;
  logic               o_def, o_sat, o_rnd, o_trn, o_ns1, o_ns5;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic v;
    int   a;
    int   b;
  } pair_t;

  pair_t hist[$];

  cordic_mul_pipe u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_def), .dout(d_def), .ovf(o_def)
  );

  cordic_mul_pipe #(.SAT(1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_sat), .dout(d_sat), .ovf(o_sat)
  );

  cordic_mul_pipe #(.FRAC_SHIFT(4), .ROUND_MODE(1)) u_rnd (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_rnd), .dout(d_rnd), .ovf(o_rnd)
  );

  cordic_mul_pipe #(.FRAC_SHIFT(4), .ROUND_MODE(0)) u_trn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_trn), .dout(d_trn), .ovf(o_trn)
  );

  cordic_mul_pipe #(.NUM_STAGE(1)) u_ns1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_ns1), .dout(d_ns1), .ovf(o_ns1)
  );

  cordic_mul_pipe #(
    .NUM_STAGE(5), .FRAC_SHIFT(5), .ROUND_MODE(1), .SAT(1)
  ) u_ns5 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
    .out_valid(v_ns5), .dout(d_ns5), .ovf(o_ns5)
  );

  // Returns {ovf, dout} for a 30-bit output using plain 64-bit arithmetic.
  function automatic logic [30:0] model(
    int a, int b, int fs, int rm, int sat
  );
    longint p, s, d, maxv, minv;
    logic   o;
    maxv = (longint'(1) << 29) - 1;
    minv = -maxv - 1;
    p = longint'(a) * longint'(b);
    if (rm != 0 && fs > 0) p = p + (longint'(1) << (fs - 1));
    s = p >>> fs;
    o = (s > maxv) || (s < minv);
    d = s;
    if (sat != 0 && o) d = (s < 0) ? minv : maxv;
    return {o, d[29:0]};
  endfunction

  task automatic drive(logic v, int a, int b);
    in_valid = v;
    din0 = 17'(a);
    din1 = 16'(b);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ce = 1'b1;
    drive(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    tests++;
    if ({v_def, d_def, o_def} !== 32'd0) begin
      fails++;
      $display("FAIL reset_def got v=%b d=%0d o=%b want 0 0 0",
               v_def, d_def, o_def);
    end
    tests++;
    if ({v_ns5, d_ns5, o_ns5} !== 32'd0) begin
      fails++;
      $display("FAIL reset_ns5 got v=%b d=%0d o=%b want 0 0 0",
               v_ns5, d_ns5, o_ns5);
    end
    tests++;
    if (v_ns1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ns1_v got %b want 0", v_ns1);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int beats = 0;
    logic ev;
    @(negedge clk);
    drive(1'b1, 3, -5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(1'b0, 0, 0);
      ev = (k == 2);
      tests++;
      if (v_def !== ev) begin
        fails++;
        $display("FAIL single_v k=%0d got %b want %b", k, v_def, ev);
      end
      if (v_def === 1'b1) beats++;
      if (ev) begin
        tests++;
        if (d_def !== 30'(-15) || o_def !== 1'b0) begin
          fails++;
          $display("FAIL single_d got %0d/%b want -15/0", d_def, o_def);
        end
        tests++;
        if (v_sat !== 1'b1 || d_sat !== 30'(-15) || o_sat !== 1'b0) begin
          fails++;
          $display("FAIL single_sat got %b %0d/%b want 1 -15/0",
                   v_sat, d_sat, o_sat);
        end
      end
    end
    tests++;
    if (beats != 1) begin
      fails++;
      $display("FAIL single_beats got %0d want 1", beats);
    end
  endtask

  task automatic test_ce_stall;
    int   pa[4] = '{1, 2, -3, 100};
    int   pb[4] = '{1, -2, 3, 200};
    logic ce_prev = 1'b1;
    logic [30:0] e;
    logic signed [29:0] got[$];
    for (int m = 0; m <= 10; m++) begin
      @(negedge clk);
      if (v_def === 1'b1 && ce_prev) got.push_back(d_def);
      if (m >= 3 && m <= 5) begin
        tests++;
        if (v_def !== 1'b1 || d_def !== 30'(1)) begin
          fails++;
          $display("FAIL ce_hold m=%0d got %b %0d want 1 1",
                   m, v_def, d_def);
        end
      end
      case (m)
        0: begin ce = 1'b1; drive(1'b1, pa[0], pb[0]); end
        1: drive(1'b1, pa[1], pb[1]);
        2: begin ce = 1'b0; drive(1'b0, 0, 0); end
        5: begin ce = 1'b1; drive(1'b1, pa[2], pb[2]); end
        6: drive(1'b1, pa[3], pb[3]);
        default: drive(1'b0, 0, 0);
      endcase
      ce_prev = ce;
    end
    tests++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL ce_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      e = model(pa[i], pb[i], 0, 0, 0);
      tests++;
      if (got[i] !== e[29:0]) begin
        fails++;
        $display("FAIL ce_order i=%0d got %0d want %0d",
                 i, got[i], $signed(e[29:0]));
      end
    end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    drive(1'b1, -65536, -32768);
    @(negedge clk);
    drive(1'b0, 0, 0);
    @(negedge clk);
    tests++;
    if (v_def !== 1'b1 || d_def !== 30'd0 || o_def !== 1'b1) begin
      fails++;
      $display("FAIL ovf_wrap got %b %0d/%b want 1 0/1",
               v_def, d_def, o_def);
    end
    tests++;
    if (v_sat !== 1'b1 || d_sat !== 30'd536870911 || o_sat !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sat got %b %0d/%b want 1 536870911/1",
               v_sat, d_sat, o_sat);
    end
  endtask

  task automatic test_round;
    int er[2] = '{1, -1};
    int et[2] = '{0, -1};
    @(negedge clk);
    drive(1'b1, 3, 3);
    @(negedge clk);
    drive(1'b1, -3, 3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 0, 0);
      tests++;
      if (v_rnd !== 1'b1 || d_rnd !== 30'(er[k]) || o_rnd !== 1'b0) begin
        fails++;
        $display("FAIL round_half_up k=%0d got %b %0d/%b want 1 %0d/0",
                 k, v_rnd, d_rnd, o_rnd, er[k]);
      end
      tests++;
      if (v_trn !== 1'b1 || d_trn !== 30'(et[k]) || o_trn !== 1'b0) begin
        fails++;
        $display("FAIL round_trunc k=%0d got %b %0d/%b want 1 %0d/0",
                 k, v_trn, d_trn, o_trn, et[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ev;
    @(negedge clk);
    drive(1'b1, 7, 9);
    @(negedge clk);
    drive(1'b1, -11, 13);
    @(negedge clk);
    drive(1'b0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({v_def, d_def, o_def} !== 32'd0 ||
          {v_ns5, d_ns5, o_ns5} !== 32'd0) begin
        fails++;
        $display("FAIL mid_reset k=%0d got def %b %0d %b ns5 %b %0d %b",
                 k, v_def, d_def, o_def, v_ns5, d_ns5, o_ns5);
      end
      @(negedge clk);
    end
    drive(1'b1, 20, -30);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1'b0, 0, 0);
      ev = (k == 2);
      tests++;
      if (v_def !== ev || (ev && d_def !== 30'(-600))) begin
        fails++;
        $display("FAIL mid_restart k=%0d got %b %0d want %b -600",
                 k, v_def, d_def, ev);
      end
    end
  endtask

  task automatic test_sweep(int n);
    pair_t p;
    logic [30:0] e;
    hist.delete();
    ce = 1'b1;
    for (int i = 0; i < n + 5; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        p = hist[i-1];
        tests++;
        if (v_ns1 !== p.v) begin
          fails++;
          $display("FAIL ns1_v i=%0d got %b want %b", i, v_ns1, p.v);
        end
        e = model(p.a, p.b, 0, 0, 0);
        if (p.v) begin
          tests++;
          if ({o_ns1, d_ns1} !== e) begin
            fails++;
            $display("FAIL ns1_d a=%0d b=%0d got %0d/%b want %0d/%b",
                     p.a, p.b, d_ns1, o_ns1, $signed(e[29:0]), e[30]);
          end
        end
      end
      if (i >= 2) begin
        p = hist[i-2];
        e = model(p.a, p.b, 0, 0, 0);
        tests++;
        if (v_def !== p.v || (p.v && {o_def, d_def} !== e)) begin
          fails++;
          $display("FAIL def_rand a=%0d b=%0d got %b %0d/%b want %b %0d/%b",
                   p.a, p.b, v_def, d_def, o_def,
                   p.v, $signed(e[29:0]), e[30]);
        end
      end
      if (i >= 4) begin
        p = hist[i-4];
        e = model(p.a, p.b, 5, 1, 1);
        tests++;
        if (v_ns5 !== p.v || (p.v && {o_ns5, d_ns5} !== e)) begin
          fails++;
          $display("FAIL ns5_rand a=%0d b=%0d got %b %0d/%b want %b %0d/%b",
                   p.a, p.b, v_ns5, d_ns5, o_ns5,
                   p.v, $signed(e[29:0]), e[30]);
        end
      end
      if (i < n) begin
        p.v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: begin
            p.a = int'($urandom_range(0, 8191)) - 4096;
            p.b = int'($urandom_range(0, 8191)) - 4096;
          end
          1: begin
            p.a = ($urandom_range(0, 1) != 0) ? -65536 : 65535;
            p.b = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
          end
          default: begin
            p.a = int'($urandom_range(0, 131071)) - 65536;
            p.b = int'($urandom_range(0, 65535)) - 32768;
          end
        endcase
      end else begin
        p.v = 1'b0;
        p.a = 0;
        p.b = 0;
      end
      hist.push_back(p);
      drive(p.v, p.a, p.b);
    end
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    drive(1'b0, 0, 0);
    test_reset();
    test_single();
    test_ce_stall();
    test_overflow();
    test_round();
    test_reset_mid();
    test_sweep(10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_mul_pipe.md
# cordic_mul_pipe

Parametrised, pipelined signed multiplier for the CORDIC fixed-point datapath. It replaces the purely combinational multiply unit with a configurable number of pipeline stages, plus clock-enable and a valid sideband. The product is post-processed with a fractional right shift, optional round-half-up, and wrap or saturate narrowing, and an overflow flag is produced. It is instantiated wherever the scaled CORDIC outputs are multiplied by gain constants or by each other.

## Interface
- ID, 1: instance identifier; no functional effect.
- NUM_STAGE, 3: total stages, 1..5. Register latency L = NUM_STAGE-1; NUM_STAGE=1 is fully combinational.
- din0_WIDTH, 17: signed width of din0.
- din1_WIDTH, 16: signed width of din1.
- dout_WIDTH, 30: signed width of dout.
- FRAC_SHIFT, 0: arithmetic right shift applied to the full product, 0..din0_WIDTH+din1_WIDTH-2.
- ROUND_MODE, 0: 0 = truncate (floor); 1 = round half up before the shift. Ignored when FRAC_SHIFT=0.
- SAT, 0: 0 = wrap (keep the low dout_WIDTH bits); 1 = clamp to the signed dout range.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable for all pipeline registers.
- in_valid  in  1  din0/din1 carry an operand pair this cycle.
- din0  in  din0_WIDTH  signed operand A.
- din1  in  din1_WIDTH  signed operand B.
- out_valid  out  1  dout/ovf carry a result.
- dout  out  dout_WIDTH  signed processed product.
- ovf  out  1  the shifted and rounded value did not fit in dout_WIDTH.

## Operation
- Full product: p = din0 * din1, signed, P = din0_WIDTH + din1_WIDTH bits. Exact, with no intermediate truncation.
- Rounding: if ROUND_MODE=1 and FRAC_SHIFT>0, compute r = p + 2^(FRAC_SHIFT-1) in P+1 bits. Otherwise r = p sign-extended to P+1 bits.
- Shift: s = r >>> FRAC_SHIFT (arithmetic shift).
- Range check: ovf = 1 when s < -2^(dout_WIDTH-1) or s > 2^(dout_WIDTH-1)-1.
- Narrowing:
  - SAT=0: dout = s[dout_WIDTH-1:0].
  - SAT=1 and ovf: dout = the most negative code if s<0, else the most positive code.
  - Otherwise dout = s.
- ovf is reported in both SAT modes.
- Valid pipeline: in_valid travels through L registers alongside the data. out_valid is in_valid delayed by L ce-qualified cycles.
- Data registers load regardless of in_valid. dout and ovf are don't-care when out_valid=0, except after reset (see below).
- ce=0: every data and valid register holds its value, so outputs are frozen. No result is dropped or duplicated.
- Placement of the multiply, round and saturate logic across stages is free, provided latency is exactly L and the design sustains one result per ce cycle.

## Timing
- Reset (reset=1 at a rising edge) has priority over ce. It clears all valid bits, data registers, dout and ovf to 0.
- For NUM_STAGE>1, out_valid=0, dout=0 and ovf=0 in the cycle after reset and until new data emerges.
- Reset mid-stream: all in-flight operands are discarded. The first out_valid after reset is produced L ce-cycles after the first post-reset in_valid.
- With ce held high: an operand pair sampled at edge n appears on dout/out_valid after edge n+L-1, so it is observable in cycle n+L.
- With ce held high, throughput is one operand pair per cycle; back-to-back in_valid is supported indefinitely.
- NUM_STAGE=1: dout, ovf and out_valid are combinational from the inputs (out_valid = in_valid), and reset and ce have no effect.
- There is no backpressure input. The consumer must accept every out_valid beat or stall the whole pipe with ce.

## Test plan
- Default parameters, din0=3, din1=-5, one in_valid pulse → exactly one out_valid beat two cycles later with dout=-15 and ovf=0.
- Default parameters, stream pairs (1,1), (2,-2), (-3,3), (100,200) back-to-back, with ce dropped for 3 cycles after the second input → outputs 1, -4, -9, 20000 in order, each appearing once. Outputs hold during the ce=0 gap and latency counts only ce=1 cycles.
- din0=-65536, din1=-32768 (p=2^31) → with SAT=1: dout=536870911, ovf=1. With SAT=0: dout=0, ovf=1.
- FRAC_SHIFT=4 on input (3,3), p=9 → ROUND_MODE=1 gives dout=1; ROUND_MODE=0 gives dout=0. Input (-3,3), p=-9 → dout=-1 in both modes. ovf=0 in all cases.
- Two valid pairs in flight, reset held high for one cycle → out_valid stays 0 with dout=0 and ovf=0 until a new in_valid has propagated L cycles.
- NUM_STAGE=1 and NUM_STAGE=5 sweeps with 10,000 random operand pairs checked against a reference model → bit-exact dout and ovf at latency 0 and 4 respectively.
